// File: rtl/bmp_pkg.sv
// ============================================================================
// Module  : bmp_pkg
// Brief   : Shared types and constants for the BMP word-stream controller.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package bmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_SKIP  = 3'd2,
        ST_PIXEL = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ERR   = 3'd5
    } bmp_state_t;

    localparam logic [15:0] BMP_SIG   = 16'h4D42;
    localparam logic [15:0] BPP_32    = 16'd32;
    localparam int unsigned HDR_WORDS = 8;

    // Header word indices (32-bit words of the file)
    localparam logic [2:0] C_WORD_SIG    = 3'd0;
    localparam logic [2:0] C_WORD_OFF_LO = 3'd2;
    localparam logic [2:0] C_WORD_OFF_HI = 3'd3;
    localparam logic [2:0] C_WORD_W_LO   = 3'd4;
    localparam logic [2:0] C_WORD_WH     = 3'd5;
    localparam logic [2:0] C_WORD_H_HI   = 3'd6;
    localparam logic [2:0] C_WORD_BPP    = 3'd7;

endpackage : bmp_pkg

`default_nettype wire

// File: rtl/bmp_hdr_capture.sv
// ============================================================================
// Module  : bmp_hdr_capture
// Brief   : Captures BMP header fields from words 0..6 and validates the
//           header on word 7 when BMP_HDR_CHECK_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module bmp_hdr_capture
    import bmp_pkg::*;
#(
    parameter int MAX_DIM = 1024,
    parameter int DIM_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [2:0]       word_idx,
    input  logic [31:0]      data,
    output logic [31:0]      offset,
    output logic [DIM_W-1:0] width,
    output logic [DIM_W-1:0] height,
    output logic             hdr_ok
);

    logic [15:0] r_sig;
    logic [31:0] r_offset;
    logic [31:0] r_width;
    logic [31:0] r_height;

    // Fields straddle word boundaries, so each half lands on its own word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig    <= '0;
            r_offset <= '0;
            r_width  <= '0;
            r_height <= '0;
        end else if (capture) begin
            case (word_idx)
                C_WORD_SIG:    r_sig            <= data[15:0];
                C_WORD_OFF_LO: r_offset[15:0]   <= data[31:16];
                C_WORD_OFF_HI: r_offset[31:16]  <= data[15:0];
                C_WORD_W_LO:   r_width[15:0]    <= data[31:16];
                C_WORD_WH: begin
                    r_width[31:16] <= data[15:0];
                    r_height[15:0] <= data[31:16];
                end
                C_WORD_H_HI:   r_height[31:16]  <= data[15:0];
                default: ;
            endcase
        end
    end

    assign offset = r_offset;
    assign width  = r_width[DIM_W-1:0];
    assign height = r_height[DIM_W-1:0];

`ifdef BMP_HDR_CHECK_EN
    // bpp is judged live on word 7, the cycle the parent decides the exit.
    logic w_bad_sig;
    logic w_bad_bpp;
    logic w_bad_off;
    logic w_bad_width;
    logic w_bad_height;

    always_comb begin
        w_bad_sig    = (r_sig != BMP_SIG);
        w_bad_bpp    = (data[15:0] != BPP_32);
        w_bad_off    = (r_offset[1:0] != 2'b00) || (r_offset < 32'd32);
        w_bad_width  = (r_width == 32'd0) || (r_width > 32'(MAX_DIM));
        w_bad_height = (r_height == 32'd0) || r_height[31] ||
                       (r_height > 32'(MAX_DIM));
        hdr_ok       = !(w_bad_sig || w_bad_bpp || w_bad_off ||
                         w_bad_width || w_bad_height);
    end
`else
    wire w_unused_fields = &{1'b0, r_sig, r_width, r_height};
    assign hdr_ok = 1'b1;
`endif

endmodule : bmp_hdr_capture

`default_nettype wire

// File: rtl/bmp_stream_ctrl.sv
// ============================================================================
// Module  : bmp_stream_ctrl
// Brief   : Parses a 32bpp BMP word stream and emits its pixels with row/frame
//           markers. Header validation is enabled by BMP_HDR_CHECK_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module bmp_stream_ctrl
    import bmp_pkg::*;
#(
    parameter int MAX_DIM = 1024,
    parameter int DIM_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [31:0]      pix_data,
    output logic             pix_eol,
    output logic             pix_eof,
    output logic [DIM_W-1:0] width,
    output logic [DIM_W-1:0] height,
    output logic             busy,
    output logic             done,
    output logic             hdr_err
);

`ifdef BMP_HDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam logic [DIM_W-1:0] C_ONE = DIM_W'(1);

    bmp_state_t       r_state;
    logic [31:0]      r_word_idx;
    logic [DIM_W-1:0] r_col;
    logic [DIM_W-1:0] r_row;
    logic             r_pix_valid;
    logic [31:0]      r_pix_data;
    logic             r_eol;
    logic             r_eof;
    logic             r_done;
    logic             r_hdr_err;

    logic        w_accept;
    logic        w_out_xfer;
    logic        w_last_col;
    logic        w_last_row;
    logic        w_hdr_ok;
    logic [31:0] w_offset;
    logic [31:0] w_skip_end;

    bmp_hdr_capture #(
        .MAX_DIM (MAX_DIM),
        .DIM_W   (DIM_W)
    ) u_hdr (
        .clk      (clk),
        .rst      (reset),
        .capture  (w_accept && (r_state == ST_HDR)),
        .word_idx (r_word_idx[2:0]),
        .data     (in_data),
        .offset   (w_offset),
        .width    (width),
        .height   (height),
        .hdr_ok   (w_hdr_ok)
    );

    always_comb begin
        in_ready = 1'b0;
        if (enable) begin
            case (r_state)
                ST_HDR, ST_SKIP: in_ready = 1'b1;
                ST_PIXEL:        in_ready = pix_ready || !r_pix_valid;
                default:         in_ready = 1'b0;
            endcase
        end
    end

    assign w_accept   = in_valid && in_ready;
    assign w_out_xfer = r_pix_valid && pix_ready;
    assign w_last_col = (r_col == width - C_ONE);
    assign w_last_row = (r_row == height - C_ONE);
    // First pixel word index; offsets below the header collapse to no skip.
    assign w_skip_end = {2'b00, w_offset[31:2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_word_idx  <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
            r_done      <= 1'b0;
            r_hdr_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Downstream transfers complete even while the FSM is frozen.
            if (w_out_xfer) begin
                r_pix_valid <= 1'b0;
            end
            if (enable) begin
                case (r_state)
                    ST_IDLE, ST_ERR: begin
                        if (start) begin
                            r_state    <= ST_HDR;
                            r_hdr_err  <= 1'b0;
                            r_word_idx <= '0;
                            r_col      <= '0;
                            r_row      <= '0;
                        end
                    end
                    ST_HDR: begin
                        if (w_accept) begin
                            r_word_idx <= r_word_idx + 32'd1;
                            if (r_word_idx == HDR_WORDS - 1) begin
                                if (CHECK_EN && !w_hdr_ok) begin
                                    r_state   <= ST_ERR;
                                    r_hdr_err <= 1'b1;
                                end else if (w_skip_end <= HDR_WORDS) begin
                                    r_state <= ST_PIXEL;
                                end else begin
                                    r_state <= ST_SKIP;
                                end
                            end
                        end
                    end
                    ST_SKIP: begin
                        if (w_accept) begin
                            r_word_idx <= r_word_idx + 32'd1;
                            if (r_word_idx + 32'd1 == w_skip_end) begin
                                r_state <= ST_PIXEL;
                            end
                        end
                    end
                    ST_PIXEL: begin
                        if (w_accept) begin
                            r_pix_valid <= 1'b1;
                            r_pix_data  <= in_data;
                            r_eol       <= w_last_col;
                            r_eof       <= w_last_col && w_last_row;
                            if (w_last_col) begin
                                r_col <= '0;
                                r_row <= r_row + C_ONE;
                            end else begin
                                r_col <= r_col + C_ONE;
                            end
                            if (w_last_col && w_last_row) begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (!r_pix_valid || pix_ready) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pix_valid = r_pix_valid;
    assign pix_data  = r_pix_data;
    assign pix_eol   = r_eol;
    assign pix_eof   = r_eof;
    assign done      = r_done;
    assign hdr_err   = CHECK_EN ? r_hdr_err : 1'b0;
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_ERR);

endmodule : bmp_stream_ctrl

`default_nettype wire

// File: tb/tb_bmp_stream_ctrl.sv
// ============================================================================
// Module  : tb_bmp_stream_ctrl
// Brief   : Self-checking bench for bmp_stream_ctrl (honours BMP_HDR_CHECK_EN).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bmp_stream_ctrl;

    typedef struct {
        logic [31:0] d;
        logic        eol;
        logic        eof;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] pix_data;
    logic        pix_eol;
    logic        pix_eof;
    logic [15:0] width;
    logic [15:0] height;
    logic        busy;
    logic        done;
    logic        hdr_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] file_q[$];
    pix_t        exp_q[$];
    int          feed_idx  = 0;
    bit          feed_en   = 0;
    int          first_w   = 0;
    int          npix      = 0;
    int          rdy_mode  = 0;
    int          pix_cnt   = 0;
    int          eol_cnt   = 0;
    int          done_cnt  = 0;
    logic [31:0] pix_log[int];

    bmp_stream_ctrl #(.MAX_DIM(1024), .DIM_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_eol   (pix_eol),
        .pix_eof   (pix_eof),
        .width     (width),
        .height    (height),
        .busy      (busy),
        .done      (done),
        .hdr_err   (hdr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm, input int act, input int req);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", nm, act, req);
    endtask

    // Reference: file = 8 header words, skip filler, pixels, 3 trailing words.
    task automatic load_frame(input int off_b, input int w, input int h,
                              input logic [15:0] sig, input logic [15:0] bpp,
                              input bit good);
        logic [31:0] ob, wb, hb;
        pix_t p;
        ob = off_b; wb = w; hb = h;
        file_q.delete();
        exp_q.delete();
        file_q.push_back({16'h0000, sig});
        file_q.push_back(32'h0);
        file_q.push_back({ob[15:0], 16'h0000});
        file_q.push_back({16'd40, ob[31:16]});
        file_q.push_back({wb[15:0], 16'h0000});
        file_q.push_back({hb[15:0], wb[31:16]});
        file_q.push_back({16'd1, hb[31:16]});
        file_q.push_back({16'd0, bpp});
        for (int k = 8; k < off_b / 4 + w * h + 3; k++)
            file_q.push_back(32'hC0DE_0000 | k);
        first_w = off_b / 4;
        npix    = good ? w * h : 0;
        for (int i = 0; i < npix; i++) begin
            p.d   = file_q[first_w + i];
            p.eol = ((i % w) == w - 1);
            p.eof = (i == w * h - 1);
            exp_q.push_back(p);
        end
        feed_idx = 0;
        feed_en  = 1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input int base);
        int k;
        for (k = 0; k < 400 && done_cnt == base; k++) @(posedge clk);
        if (done_cnt == base) fail_now("done_timeout", k, 400);
    endtask

    task automatic wait_pix(input int n);
        int k;
        for (k = 0; k < 400 && pix_cnt < n; k++) @(posedge clk);
        if (pix_cnt < n) fail_now("pix_timeout", pix_cnt, n);
    endtask

    task automatic frame_end_checks(input int off_b, input int w, input int h,
                                    input int pbase, input int dbase);
        repeat (4) @(posedge clk);
        #1;
        chk("pix_left", exp_q.size(), 0);
        chk("pix_count", pix_cnt - pbase, w * h);
        chk("words_used", feed_idx, off_b / 4 + w * h);
        chk("done_pulses", done_cnt - dbase, 1);
        chk("width", width, w);
        chk("height", height, h);
        chk("in_ready_idle", in_ready, 1'b0);
        chk("busy_idle", busy, 1'b0);
    endtask

    // Drives the streams at negedge, then checks outputs against the model.
    initial begin : compare
        bit          acc_pend, pend, stall, exp_done, xfer;
        logic [31:0] pend_data, hold_d;
        logic        hold_eol, hold_eof;
        logic [3:0]  rdy_pat;
        int          phase;
        pix_t        e;
        acc_pend = 0; pend = 0; stall = 0; exp_done = 0; phase = 0;
        rdy_pat  = 4'b1001;
        pix_ready = 1'b1; in_valid = 1'b0; in_data = '0;
        forever begin
            @(negedge clk);
            if (acc_pend) feed_idx++;
            acc_pend  = 0;
            phase     = (phase + 1) % 4;
            pix_ready = (rdy_mode == 0) ? 1'b1 : rdy_pat[phase];
            in_valid  = feed_en && (feed_idx < file_q.size());
            in_data   = in_valid ? file_q[feed_idx] : 32'h0;
            #1;
            if (reset) begin
                pend = 0; stall = 0; exp_done = 0;
                continue;
            end
            chk("done", done, exp_done);
            if (done) done_cnt++;
            if (pend) begin
                chk("latency_valid", pix_valid, 1'b1);
                chk("latency_data", pix_data, pend_data);
            end
            if (stall) begin
                chk("hold_valid", pix_valid, 1'b1);
                chk("hold_data", pix_data, hold_d);
                chk("hold_eol", pix_eol, hold_eol);
                chk("hold_eof", pix_eof, hold_eof);
            end
            xfer = pix_valid && pix_ready;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_pixel", pix_cnt, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_data", pix_data, e.d);
                    chk("pix_eol", pix_eol, e.eol);
                    chk("pix_eof", pix_eof, e.eof);
                end
                pix_log[pix_cnt] = pix_data;
                pix_cnt++;
                if (pix_eol) eol_cnt++;
            end
            exp_done  = xfer && pix_eof;
            stall     = pix_valid && !pix_ready;
            hold_d    = pix_data;
            hold_eol  = pix_eol;
            hold_eof  = pix_eof;
            acc_pend  = in_valid && in_ready;
            pend      = acc_pend && (feed_idx >= first_w) && (feed_idx < first_w + npix);
            pend_data = in_data;
        end
    end

    initial begin : main
        int pb, db, eb, wt0, pc0;
        reset = 1'b1; enable = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_pix_valid", pix_valid, 1'b0);
        chk("rst_pix_data", pix_data, 32'h0);
        chk("rst_eol_eof", {pix_eol, pix_eof}, 2'b00);
        chk("rst_width", width, 16'd0);
        chk("rst_height", height, 16'd0);
        chk("rst_busy_done_err", {busy, done, hdr_err}, 3'b000);
        reset = 1'b0;

        // 4x2, offset 32, always ready
        load_frame(32, 4, 2, 16'h4D42, 16'd32, 1);
        pb = pix_cnt; db = done_cnt; eb = eol_cnt;
        pulse_start();
        wait_done(db);
        frame_end_checks(32, 4, 2, pb, db);
        chk("f1_first_pix", pix_log[pb], 32'hC0DE_0008);
        chk("f1_last_pix", pix_log[pb + 7], 32'hC0DE_000F);
        chk("f1_eol_count", eol_cnt - eb, 2);
        chk("f1_words", feed_idx, 16);

        // offset 40: two words skipped
        load_frame(40, 4, 2, 16'h4D42, 16'd32, 1);
        pb = pix_cnt; db = done_cnt;
        pulse_start();
        wait_done(db);
        frame_end_checks(40, 4, 2, pb, db);
        chk("f2_first_pix", pix_log[pb], 32'hC0DE_000A);
        chk("f2_words", feed_idx, 18);

        // downstream backpressure 1,0,0,1
        rdy_mode = 1;
        load_frame(32, 4, 2, 16'h4D42, 16'd32, 1);
        pb = pix_cnt; db = done_cnt;
        pulse_start();
        wait_done(db);
        frame_end_checks(32, 4, 2, pb, db);
        rdy_mode = 0;

`ifdef BMP_HDR_CHECK_EN
        // bad bpp -> ERR, then a restart with a good file
        load_frame(32, 4, 2, 16'h4D42, 16'd24, 0);
        pulse_start();
        for (int k = 0; k < 50 && !hdr_err; k++) @(posedge clk);
        #1;
        chk("err_flag", hdr_err, 1'b1);
        chk("err_in_ready", in_ready, 1'b0);
        chk("err_busy", busy, 1'b0);
        chk("err_words", feed_idx, 8);
        load_frame(32, 4, 2, 16'h4D42, 16'd32, 1);
        pb = pix_cnt; db = done_cnt;
        pulse_start();
        chk("err_cleared", hdr_err, 1'b0);
        wait_done(db);
        frame_end_checks(32, 4, 2, pb, db);
`endif

        // reset after pixel 3, then a fresh frame
        load_frame(32, 4, 2, 16'h4D42, 16'd32, 1);
        pb = pix_cnt; db = done_cnt;
        pulse_start();
        wait_pix(pb + 4);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_pix_valid", pix_valid, 1'b0);
        chk("mid_rst_pix_data", pix_data, 32'h0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_width", width, 16'd0);
        exp_q.delete();
        feed_en = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_cnt - db, 0);
        chk("idle_after_rst", busy, 1'b0);
        load_frame(32, 4, 2, 16'h4D42, 16'd32, 1);
        pb = pix_cnt; db = done_cnt;
        pulse_start();
        wait_done(db);
        frame_end_checks(32, 4, 2, pb, db);

        // enable low for 5 cycles mid-PIXEL
        load_frame(32, 4, 2, 16'h4D42, 16'd32, 1);
        pb = pix_cnt; db = done_cnt;
        pulse_start();
        wait_pix(pb + 3);
        #1 enable = 1'b0;
        @(negedge clk); #2;
        wt0 = feed_idx; pc0 = pix_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("dis_in_ready", in_ready, 1'b0);
            chk("dis_busy", busy, 1'b1);
            if (i < 4) begin
                @(negedge clk); #2;
            end
        end
        chk("dis_words_frozen", feed_idx, wt0);
        chk("dis_pix_bounded", (pix_cnt - pc0 <= 1), 1'b1);
        @(posedge clk); #1 enable = 1'b1;
        wait_done(db);
        frame_end_checks(32, 4, 2, pb, db);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_bmp_stream_ctrl

`default_nettype wire

// File: doc/bmp_stream_ctrl.md
BMP_STREAM_CTRL -- requirements
Module: bmp_stream_ctrl

Interface
REQ-001 Parameter MAX_DIM, default 1024, maximum accepted image width and height in pixels.
REQ-002 Parameter DIM_W, default 16, width of the WIDTH/HEIGHT outputs and of the row/column counters.
REQ-003 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 ENABLE  in  1  global advance enable.
REQ-006 START  in  1  single-cycle pulse that begins a frame; honoured only in IDLE or ERR.
REQ-007 IN_VALID / IN_READY  in / out  1 / 1  BMP file word-stream handshake.
REQ-008 IN_DATA  in  32  file bytes 4k..4k+3, little-endian, for word k.
REQ-009 PIX_VALID / PIX_READY  out / in  1 / 1  pixel-stream handshake to the detection datapath.
REQ-010 PIX_DATA  out  32  one 32bpp pixel (BGRA).
REQ-011 PIX_EOL / PIX_EOF  out  1 / 1  qualify PIX_DATA as the last pixel of a row / of the frame.
REQ-012 WIDTH / HEIGHT  out  DIM_W each  captured image dimensions.
REQ-013 BUSY / DONE / HDR_ERR  out  1 each  frame in progress / 1-cycle completion pulse / header rejected.

Function
REQ-014 FSM states SHALL be IDLE, HDR, SKIP, PIXEL, DRAIN, ERR.
- IDLE + START -> HDR.
- HDR: words 0..7 consumed -> SKIP.
- SKIP: consume until word index == offset/4 -> PIXEL.
- PIXEL: last pixel accepted -> DRAIN.
- DRAIN: EOF output transfer completes -> IDLE with DONE=1 for one cycle.
REQ-015 Header fields SHALL be extracted as follows:
- sig = word0[15:0]
- offset = {word3[15:0], word2[31:16]}
- width = {word5[15:0], word4[31:16]}
- height = {word6[15:0], word5[31:16]}
- bpp = word7[15:0]
REQ-016 If offset == 32, SKIP SHALL be exited immediately (zero skip words).
REQ-017 IN_READY SHALL be 1 in HDR and SKIP, and (PIX_READY || !PIX_VALID) in PIXEL; it SHALL be 0 otherwise, or whenever ENABLE=0.
REQ-018 Output register SHALL have 1-cycle latency: an input word accepted at cycle n appears on PIX_DATA at n+1.
REQ-019 PIX_DATA/EOL/EOF SHALL hold stable while PIX_VALID && !PIX_READY.
REQ-020 Column counter SHALL wrap to 0 at WIDTH-1, with PIX_EOL=1 on that pixel; the row counter SHALL increment on wrap; PIX_EOF=1 on pixel WIDTH*HEIGHT-1.
REQ-021 Words offered after the last pixel SHALL NOT be consumed.
REQ-022 ENABLE=0 SHALL freeze the FSM and counters; a pending output transfer SHALL still complete.
REQ-023 START outside IDLE/ERR SHALL be ignored; START in ERR SHALL clear HDR_ERR and enter HDR.
REQ-024 BUSY SHALL equal (state != IDLE && state != ERR).
REQ-025 Rows SHALL be emitted in file order (bottom-up); no reordering.

Reset
REQ-026 RESET SHALL force IDLE and zero counters; outputs SHALL be IN_READY=0, PIX_VALID=0, PIX_DATA=0, PIX_EOL=0, PIX_EOF=0, WIDTH=0, HEIGHT=0, BUSY=0, DONE=0, HDR_ERR=0.
REQ-027 Reset mid-frame SHALL drop any pending pixel with no DONE; the next frame SHALL require START.

Configuration
REQ-028 With BMP_HDR_CHECK_EN defined, the block SHALL enter ERR (HDR_ERR=1, IN_READY=0) at the end of HDR if any of the following hold: sig != 16'h4D42; bpp != 32; offset%4 != 0 or offset < 32; width == 0 or width > MAX_DIM; height == 0, height[31] set, or height > MAX_DIM.
REQ-029 Without BMP_HDR_CHECK_EN, no checks SHALL be performed, HDR_ERR SHALL be tied 0, and ERR SHALL be unreachable.

Structure
REQ-030 Package bmp_pkg SHALL hold the state enum, header word indices, BMP_SIG=16'h4D42, BPP_32=32, and HDR_WORDS=8.
REQ-031 Sub-module bmp_hdr_capture SHALL perform header field capture and checks; the FSM, counters and output register SHALL be in the parent.

Verification
REQ-032 4x2 image, offset 32, sig 0x4D42, bpp 32, PIX_READY=1 -> 8 pixels in order; EOL on pixels 3 and 7; EOF on pixel 7; DONE one cycle after pixel 7; WIDTH=4, HEIGHT=2.
REQ-033 Same image with offset 40 -> 2 words skipped; first pixel is word 10.
REQ-034 PIX_READY toggling 1,0,0,1 during PIXEL -> no pixel lost or duplicated; data held stable during stalls.
REQ-035 (BMP_HDR_CHECK_EN) bpp=24 -> HDR_ERR=1 after word 7 and IN_READY=0; START -> HDR_ERR=0 and re-parse succeeds.
REQ-036 RESET asserted after pixel 3 of 8 -> all outputs at reset values same cycle; next START with a fresh file -> correct 8-pixel frame.
REQ-037 ENABLE=0 for 5 cycles mid-PIXEL -> IN_READY=0; counters frozen; frame completes correctly after re-enable.
